// File: rtl/iq_demod_decimator_if.sv
// rtl/iq_demod_decimator_if.sv - sample stream in, I/Q result stream out
// Purpose: bundles the per-channel sample input and I/Q result output of
//          iq_demod_decimator.
// Signals: data_i/data_valid_i/sync_i/mode_i  sample side (master drives)
//          I_data_o/Q_data_o/data_valid_o     result side (slave drives)
//          ready_i                            downstream accept (master drives)
//          overrun_o                          sticky drop flag (slave drives)
interface iq_demod_decimator_if #(
    parameter int N_CH   = 128,
    parameter int DATA_W = 10
);
    logic [N_CH*DATA_W-1:0] data_i;
    logic                   data_valid_i;
    logic                   sync_i;
    logic                   mode_i;
    logic [N_CH*DATA_W-1:0] I_data_o;
    logic [N_CH*DATA_W-1:0] Q_data_o;
    logic                   data_valid_o;
    logic                   ready_i;
    logic                   overrun_o;

    modport master (
        output data_i, data_valid_i, sync_i, mode_i, ready_i,
        input  I_data_o, Q_data_o, data_valid_o, overrun_o
    );

    modport slave (
        input  data_i, data_valid_i, sync_i, mode_i, ready_i,
        output I_data_o, Q_data_o, data_valid_o, overrun_o
    );
endinterface

// File: rtl/iq_demod_decimator.sv
// rtl/iq_demod_decimator.sv - fs/4 I/Q demodulation with boxcar decimation
// Purpose: per channel, mixes the sample stream by fs/4 into I and Q, sums
//          DEC accepted samples, rounds and divides by DEC, and offers one
//          I/Q word per channel per block on a held output register.
//          Bypass mode sums the real samples into I and keeps Q at zero.
// Ports:   clk_i     clock
//          reset_ni  asynchronous active-low reset
//          bus       slave side of iq_demod_decimator_if
module iq_demod_decimator #(
    parameter int N_CH   = 128,
    parameter int DATA_W = 10,
    parameter int DEC    = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    iq_demod_decimator_if.slave  bus
);
    localparam int K     = $clog2(DEC);
    localparam int ACC_W = DATA_W + K + 1;
    localparam logic [K-1:0] DC_LAST = K'(DEC - 1);
    localparam logic [K-1:0] DC_ONE  = K'(1);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(DEC / 2);

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    out_state_t state_q, state_d;
    logic [1:0]   ph_q, eff_ph;
    logic [K-1:0] dc_q, eff_dc;
    logic         mode_q, eff_mode;
    logic         accept, restart, dump, load, drop;

    logic [N_CH*DATA_W-1:0] res_i, res_q;
    logic [N_CH*DATA_W-1:0] i_q, q_q;
    logic                   ovr_q;

    // A qualified sync makes the current sample index 0 of a new block in
    // the mode presented alongside it.
    assign accept   = bus.data_valid_i;
    assign restart  = accept && bus.sync_i;
    assign eff_ph   = restart ? 2'd0 : ph_q;
    assign eff_dc   = restart ? '0 : dc_q;
    assign eff_mode = restart ? bus.mode_i : mode_q;
    // DEC >= 2, so a restarted sample (dc = 0) can never be the dump sample.
    assign dump     = accept && (eff_dc == DC_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ph_q   <= 2'd0;
            dc_q   <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            ph_q   <= eff_ph + 2'd1;
            dc_q   <= eff_dc + DC_ONE;
            mode_q <= eff_mode;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [DATA_W-1:0]       raw;
        logic signed [ACC_W-1:0] x, ci, cq, base_i, base_q, sum_i, sum_q;
        logic signed [ACC_W-1:0] rnd_i, rnd_q, acc_i, acc_q;
        logic                    unused_rnd;

        assign raw = bus.data_i[c*DATA_W +: DATA_W];
        assign x   = {{(K+1){raw[DATA_W-1]}}, raw};

        always_comb begin
            ci = '0;
            cq = '0;
            if (eff_mode) begin
                ci = x;
            end else begin
                case (eff_ph)
                    2'd0: ci = x;
                    2'd1: cq = -x;
                    2'd2: ci = -x;
                    2'd3: cq = x;
                endcase
            end
        end

        assign base_i = restart ? '0 : acc_i;
        assign base_q = restart ? '0 : acc_q;
        assign sum_i  = base_i + ci;
        assign sum_q  = base_q + cq;
        // Round half up, then arithmetic divide by DEC. The magnitude of a
        // block average never exceeds the input range, so the low DATA_W
        // bits carry the whole result.
        assign rnd_i  = (sum_i + HALF) >>> K;
        assign rnd_q  = (sum_q + HALF) >>> K;
        assign res_i[c*DATA_W +: DATA_W] = rnd_i[DATA_W-1:0];
        assign res_q[c*DATA_W +: DATA_W] = rnd_q[DATA_W-1:0];
        assign unused_rnd = ^{rnd_i[ACC_W-1:DATA_W], rnd_q[ACC_W-1:DATA_W]};

        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                acc_i <= '0;
                acc_q <= '0;
            end else if (accept) begin
                acc_i <= dump ? '0 : sum_i;
                acc_q <= dump ? '0 : sum_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output register occupancy: a dump loads when the register is empty or
    // is being drained on the same edge; otherwise the result is dropped.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (dump) begin
                    load    = 1'b1;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (dump) begin
                    if (bus.ready_i) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (bus.ready_i) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            i_q   <= '0;
            q_q   <= '0;
            ovr_q <= 1'b0;
        end else begin
            if (load) begin
                i_q <= res_i;
                q_q <= res_q;
            end
            if (drop) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign bus.I_data_o     = i_q;
    assign bus.Q_data_o     = q_q;
    assign bus.data_valid_o = (state_q == OUT_FULL);
    assign bus.overrun_o    = ovr_q;
endmodule

// File: doc/iq_demod_decimator.md
Name: iq_demod_decimator

Overview:
- Parametrised successor to the fixed 128-channel, 10-bit compression signal-processing stage.
- Performs fs/4 quadrature demodulation on N_CH parallel RF channels, followed by a boxcar (accumulate-and-dump) low-pass and decimation by DEC.
- Emits one I and one Q word per channel per DEC accepted samples.
- Adds three features: acquisition sync, a bypass (real-average) mode, and output backpressure with overrun detection.
- Sits between the per-acquisition sample stream and the compression/packing stage.

Parameters:
N_CH, 128, number of parallel channels
DATA_W, 10, signed two's-complement sample width (input and output)
DEC, 4, decimation factor; power of two, 2..64; K = log2(DEC)

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
data_i  in  N_CH*DATA_W  channel c in bits [DATA_W*c+DATA_W-1 : DATA_W*c], signed
data_valid_i  in  1  sample strobe; data_i is accepted on every clk_i edge where it is high
sync_i  in  1  marks the first sample of an acquisition; qualified by data_valid_i
mode_i  in  1  0 = IQ demod, 1 = bypass (real boxcar average, Q = 0); latched on qualified sync
I_data_o  out  N_CH*DATA_W  in-phase results, same packing as data_i
Q_data_o  out  N_CH*DATA_W  quadrature results, same packing
data_valid_o  out  1  output register holds an unconsumed result
ready_i  in  1  downstream accepts; a transfer occurs when data_valid_o && ready_i at a clk_i edge
overrun_o  out  1  sticky; a result was dropped because the output was still held

Behaviour:
- Reset (async assert, sync release):
  - I_data_o = 0, Q_data_o = 0, data_valid_o = 0, overrun_o = 0.
  - Phase counter ph = 0, decimation counter dc = 0, all accumulators = 0, latched mode = 0.
  - Reset mid-acquisition discards partial sums; no output is produced for them.
- Accumulators: one I and one Q per channel, width DATA_W+K+1, signed.
- Sample acceptance (data_valid_i = 1):
  - If sync_i = 1: the sample is index 0. Use ph = 0, dc = 0, discard prior partial sums, and latch mode_i (the new mode applies to this sample).
  - Otherwise sync_i is ignored.
  - Contribution of sample x in demod mode:
    - ph 0: I += x
    - ph 1: Q -= x
    - ph 2: I -= x
    - ph 3: Q += x
  - Contribution in bypass mode: I += x every sample; Q stays 0.
  - ph increments mod 4 and dc increments mod DEC on each accepted sample.
- Dump: on the accepting edge where dc == DEC-1:
  - sum = acc + contribution; result = (sum + 2^(K-1)) >>> K (round half up, arithmetic shift).
  - The result always fits DATA_W; no saturation path. The bench asserts the truncated bits equal sign extension.
  - Accumulators load 0 (or x's contribution, if this same sample carries sync; sync then restarts the count and no dump occurs).
  - The result loads the output registers if (!data_valid_o || ready_i); data_valid_o = 1 from the next cycle (latency 1 clock after the last sample).
  - Otherwise the result is dropped, the outputs are unchanged, and overrun_o is set (sticky until reset).
- Output handshake:
  - A transfer without a simultaneous dump clears data_valid_o.
  - Transfer and dump on the same edge: the new result loads and data_valid_o stays 1.
  - I_data_o/Q_data_o are stable while data_valid_o && !ready_i.
- data_valid_i low: no state change except the output handshake.
- Gaps between valid samples are allowed; ph and dc advance only on accepted samples.
- Channels are fully independent; a single ph/dc pair is shared across all channels.

Test Plan:
1. Cosine tone, mode 0, DEC=4, all channels x = 100,0,-100,0 with sync on the first -> one result: every I = 50 (0x032), Q = 0; data_valid_o rises 1 clock after the 4th sample.
2. Sine tone x = 0,100,0,-100 with sync -> I = 0, Q = (-200+2)>>>2 = -50 (0x3CE); constant x = 100 -> I = Q = 0.
3. Bypass: sync with mode_i=1, four samples x = 511 -> I = 511 (0x1FF), Q = 0; four samples x = -512 -> I = -512 (0x200); confirms no overflow at the extremes.
4. Backpressure: ready_i held 0 across two dumps -> the first result stays on the outputs, the second is dropped, overrun_o = 1; ready_i = 1 on the cycle of a dump -> seamless replacement, data_valid_o stays 1.
5. Sync mid-block: sync after 2 samples of a block -> partial sums discarded, no output for them; the next output arrives after 4 further samples; irregular data_valid_i gaps give identical results to a gap-free stream.
6. Reset asserted after 3 samples -> all outputs 0 immediately (asynchronous); after release, a 4-sample block with no sync produces the correct result from ph = 0.
